// File: rtl/scr1_dbus_bridge.sv
// scr1_dbus_bridge
//   Bridges the core data bus (valid/ready command + response streams) onto the
//   SCR1 DMEM req/ack/resp interface. Store width and byte address come from
//   the write mask. A tag FIFO records load/store per acked request so that
//   store responses can be dropped. Load responses land in a response FIFO
//   because the SCR1 response path cannot be stalled. Credits
//   (outstanding + buffered) are capped at RSP_DEPTH, so that FIFO never overflows.
// Ports
//   clk, pipe_rst_n            clock, async active-low reset
//   dbus_cmd_*                 core command stream (valid/ready, addr/write/wdata/wmask)
//   dbus_rsp_*                 core load-response stream (valid/ready, rdata/error)
//   pipe2dmem_*_o              DMEM request (req/cmd/width/addr/wdata)
//   dmem2pipe_*_i              DMEM ack, read data, response code
module scr1_dbus_bridge #(
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        pipe_rst_n,
  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  input  logic [31:0] dbus_cmd_payload_address,
  input  logic        dbus_cmd_payload_write,
  input  logic [31:0] dbus_cmd_payload_wdata,
  input  logic [3:0]  dbus_cmd_payload_wmask,
  output logic        dbus_rsp_valid,
  input  logic        dbus_rsp_ready,
  output logic [31:0] dbus_rsp_payload_rdata,
  output logic        dbus_rsp_payload_error,
  output logic        pipe2dmem_req_o,
  output logic        pipe2dmem_cmd_o,
  output logic [1:0]  pipe2dmem_width_o,
  output logic [31:0] pipe2dmem_addr_o,
  output logic [31:0] pipe2dmem_wdata_o,
  input  logic        dmem2pipe_req_ack_i,
  input  logic [31:0] dmem2pipe_rdata_i,
  input  logic [1:0]  dmem2pipe_resp_i
);

  localparam int unsigned PW = (RSP_DEPTH > 2) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    RESP_NOTRDY = 2'b00,
    RESP_RDY_OK = 2'b01,
    RESP_RDY_ER = 2'b10
  } mem_resp_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE  = 2'b00,
    WIDTH_HWORD = 2'b01,
    WIDTH_WORD  = 2'b10
  } mem_width_e;

  logic            tag_mem_q [RSP_DEPTH];
  logic [32:0]     rsp_mem_q [RSP_DEPTH];
  logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0]   outst_q, outst_d, rsp_cnt_q, rsp_cnt_d;

  logic            can_issue, accept, done, load_done, rsp_pop;
  logic [CW:0]     credits_used;
  mem_width_e      width;
  logic [1:0]      offset;

  assign credits_used = {1'b0, outst_q} + {1'b0, rsp_cnt_q};
  assign can_issue    = credits_used < DEPTH_C;

  assign pipe2dmem_req_o   = dbus_cmd_valid & can_issue;
  assign dbus_cmd_ready    = pipe2dmem_req_o & dmem2pipe_req_ack_i;
  assign pipe2dmem_cmd_o   = dbus_cmd_payload_write;
  assign pipe2dmem_width_o = width;
  assign pipe2dmem_addr_o  = {dbus_cmd_payload_address[31:2], offset};
  assign pipe2dmem_wdata_o = dbus_cmd_payload_wdata;

  always_comb begin
    width  = WIDTH_WORD;
    offset = 2'b00;
    if (dbus_cmd_payload_write) begin
      case (dbus_cmd_payload_wmask)
        4'b0001: begin width = WIDTH_BYTE;  offset = 2'd0; end
        4'b0010: begin width = WIDTH_BYTE;  offset = 2'd1; end
        4'b0100: begin width = WIDTH_BYTE;  offset = 2'd2; end
        4'b1000: begin width = WIDTH_BYTE;  offset = 2'd3; end
        4'b0011: begin width = WIDTH_HWORD; offset = 2'd0; end
        4'b1100: begin width = WIDTH_HWORD; offset = 2'd2; end
        default: begin width = WIDTH_WORD;  offset = 2'd0; end
      endcase
    end
  end

  assign accept    = dbus_cmd_ready;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign done      = (dmem2pipe_resp_i != RESP_NOTRDY) && (outst_q != '0);
  assign load_done = done & ~tag_mem_q[tag_rd_q];
  assign rsp_pop   = dbus_rsp_valid & dbus_rsp_ready;

  assign dbus_rsp_valid         = rsp_cnt_q != '0;
  assign dbus_rsp_payload_rdata = rsp_mem_q[rsp_rd_q][31:0];
  assign dbus_rsp_payload_error = rsp_mem_q[rsp_rd_q][32];

  always_comb begin
    tag_wr_d  = accept    ? tag_wr_q + PW'(1) : tag_wr_q;
    tag_rd_d  = done      ? tag_rd_q + PW'(1) : tag_rd_q;
    rsp_wr_d  = load_done ? rsp_wr_q + PW'(1) : rsp_wr_q;
    rsp_rd_d  = rsp_pop   ? rsp_rd_q + PW'(1) : rsp_rd_q;
    outst_d   = outst_q + CW'(accept) - CW'(done);
    rsp_cnt_d = rsp_cnt_q + CW'(load_done) - CW'(rsp_pop);
  end

  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      outst_q   <= '0;
      rsp_cnt_q <= '0;
    end else begin
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      rsp_wr_q  <= rsp_wr_d;
      rsp_rd_q  <= rsp_rd_d;
      outst_q   <= outst_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // Storage arrays need no reset: entries are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (accept)
      tag_mem_q[tag_wr_q] <= dbus_cmd_payload_write;
    if (load_done)
      rsp_mem_q[rsp_wr_q] <= {dmem2pipe_resp_i == RESP_RDY_ER, dmem2pipe_rdata_i};
  end

  resp_needs_tag: assert property (@(posedge clk) disable iff (!pipe_rst_n)
    (dmem2pipe_resp_i != RESP_NOTRDY) |-> (outst_q != '0));

endmodule

// File: tb/tb_scr1_dbus_bridge.sv
module tb_scr1_dbus_bridge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, write, rsp_ready, ack;
  logic [31:0] addr, wdata, dm_rdata;
  logic [3:0]  wmask;
  logic [1:0]  resp;
  logic        cmd_ready, rsp_valid, rsp_error, req, cmd;
  logic [31:0] rsp_rdata, req_addr, req_wdata;
  logic [1:0]  req_width;

  scr1_dbus_bridge #(.RSP_DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .pipe_rst_n               (rst_n),
    .dbus_cmd_valid           (valid),
    .dbus_cmd_ready           (cmd_ready),
    .dbus_cmd_payload_address (addr),
    .dbus_cmd_payload_write   (write),
    .dbus_cmd_payload_wdata   (wdata),
    .dbus_cmd_payload_wmask   (wmask),
    .dbus_rsp_valid           (rsp_valid),
    .dbus_rsp_ready           (rsp_ready),
    .dbus_rsp_payload_rdata   (rsp_rdata),
    .dbus_rsp_payload_error   (rsp_error),
    .pipe2dmem_req_o          (req),
    .pipe2dmem_cmd_o          (cmd),
    .pipe2dmem_width_o        (req_width),
    .pipe2dmem_addr_o         (req_addr),
    .pipe2dmem_wdata_o        (req_wdata),
    .dmem2pipe_req_ack_i      (ack),
    .dmem2pipe_rdata_i        (dm_rdata),
    .dmem2pipe_resp_i         (resp)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model state: tags of acked-but-unanswered requests, and buffered load responses.
  bit          outq[$];
  logic [32:0] rspq[$];
  logic [32:0] seen[$];   // load responses handed to the core, in order
  int          n_acc = 0;

  function automatic logic [33:0] exp_width_addr(input logic w, input logic [31:0] a, input logic [3:0] m);
    logic [1:0]  wd;
    logic [31:0] ea;
    ea = a & ~32'd3;
    wd = 2'd2;
    if (w && $countones(m) == 1) begin
      wd = 2'd0;
      for (int i = 0; i < 4; i++) if (m[i]) ea = ea + 32'(i);
    end else if (w && (m == 4'b0011 || m == 4'b1100)) begin
      wd = 2'd1;
      if (m == 4'b1100) ea = ea + 32'd2;
    end
    return {wd, ea};
  endfunction

  always @(negedge clk) begin
    bit          credit, exp_req, pop, fin, tg;
    logic [33:0] wa;
    if (!rst_n) begin
      outq.delete();
      rspq.delete();
    end
    credit  = (outq.size() + rspq.size()) < DEPTH;
    exp_req = valid && credit;
    check("req", 32'(req), 32'(exp_req));
    check("cmd_ready", 32'(cmd_ready), 32'(exp_req && ack));
    if (exp_req) begin
      wa = exp_width_addr(write, addr, wmask);
      check("cmd", 32'(cmd), 32'(write));
      check("width", 32'(req_width), 32'(wa[33:32]));
      check("addr", req_addr, wa[31:0]);
      check("wdata", req_wdata, wdata);
    end
    check("rsp_valid", 32'(rsp_valid), 32'(rspq.size() > 0));
    if (rspq.size() > 0) begin
      check("rsp_rdata", rsp_rdata, rspq[0][31:0]);
      check("rsp_error", 32'(rsp_error), 32'(rspq[0][32]));
    end
    if (rst_n) begin
      pop = (rspq.size() > 0) && rsp_ready;
      fin = (resp != 2'b00) && (outq.size() > 0);
      if (rsp_valid && rsp_ready) seen.push_back({rsp_error, rsp_rdata});
      if (cmd_ready) n_acc++;
      if (pop) void'(rspq.pop_front());
      if (fin) begin
        tg = outq.pop_front();
        if (!tg) rspq.push_back({resp == 2'b10, dm_rdata});
      end
      if (exp_req && ack) outq.push_back(write);
    end
  end

  logic [31:0] last_addr;
  logic [1:0]  last_width;
  logic        last_cmd;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit got = 0;
    valid = 1; write = w; addr = a; wdata = d; wmask = m;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1; last_addr = req_addr; last_width = req_width; last_cmd = cmd;
      end
      @(posedge clk); #1;
    end
    valid = 0;
    check("send_accepted", 32'(got), 32'd1);
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d);
    resp = r; dm_rdata = d;
    @(posedge clk); #1;
    resp = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 0; valid = 0; write = 0; addr = '0; wdata = '0; wmask = '0;
    rsp_ready = 1; ack = 1; dm_rdata = '0; resp = 2'b00;
    idle(3);
    check("reset_req", 32'(req), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1;
    idle(2);

    // 1: byte store, no response to the core
    send(1, 32'h100, 32'h00AB_0000, 4'b0100);
    check("t1_width", 32'(last_width), 32'd0);
    check("t1_addr", last_addr, 32'h102);
    check("t1_cmd", 32'(last_cmd), 32'd1);
    respond(2'b01, 32'h0);
    idle(2);
    check("t1_no_rsp", 32'(seen.size()), 32'd0);

    // 2: half-word and odd-mask stores
    send(1, 32'h204, 32'h1234_0000, 4'b1100);
    check("t2a_width", 32'(last_width), 32'd1);
    check("t2a_addr", last_addr, 32'h206);
    respond(2'b01, 32'h0);
    send(1, 32'h204, 32'h0055_0055, 4'b0101);
    check("t2b_width", 32'(last_width), 32'd2);
    check("t2b_addr", last_addr, 32'h204);
    respond(2'b01, 32'h0);
    send(1, 32'h208, 32'h0, 4'b0000);
    check("t2c_width", 32'(last_width), 32'd2);
    respond(2'b01, 32'h0);
    idle(2);

    // 3: load latency
    send(0, 32'h303, 32'h0, 4'b0000);
    check("t3_addr", last_addr, 32'h300);
    check("t3_width", 32'(last_width), 32'd2);
    check("t3_cmd", 32'(last_cmd), 32'd0);
    resp = 2'b01; dm_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t3_valid_cycle_N", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    resp = 2'b00;
    check("t3_valid_N1", 32'(rsp_valid), 32'd1);
    check("t3_rdata", rsp_rdata, 32'hDEADBEEF);
    check("t3_error", 32'(rsp_error), 32'd0);
    idle(2);

    // 4: credit limit with core back-pressure
    seen.delete();
    rsp_ready = 0; base = n_acc;
    valid = 1; write = 0; addr = 32'h400;
    idle(8);
    check("t4_acked", 32'(n_acc - base), 32'd4);
    check("t4_cmd_ready_low", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) respond(2'b01, 32'h1000 + 32'(i));
    idle(2);
    check("t4_still_4", 32'(n_acc - base), 32'd4);
    rsp_ready = 1;
    for (int i = 0; i < 40 && (n_acc - base) < 6; i++) idle(1);
    valid = 0;
    check("t4_acked_total", 32'(n_acc - base), 32'd6);
    respond(2'b01, 32'h1004);
    respond(2'b01, 32'h1005);
    idle(3);
    check("t4_count", 32'(seen.size()), 32'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      check("t4_order", seen[i][31:0], 32'h1000 + 32'(i));

    // 5: interleaved load/store/load with error on the second load
    seen.delete();
    send(0, 32'h500, 32'h0, 4'b0000);
    send(1, 32'h504, 32'hCAFE_F00D, 4'b1111);
    send(0, 32'h508, 32'h0, 4'b0000);
    respond(2'b01, 32'hA1);
    respond(2'b10, 32'hB2);
    respond(2'b10, 32'hA3);
    idle(3);
    check("t5_count", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      check("t5_first", 32'(seen[0]), {31'd0, 1'b0} | 32'hA1);
      check("t5_first_err", 32'(seen[0][32]), 32'd0);
      check("t5_second", seen[1][31:0], 32'hA3);
      check("t5_second_err", 32'(seen[1][32]), 32'd1);
    end

    // 6: reset with 2 outstanding and 1 buffered
    rsp_ready = 0;
    send(0, 32'h600, 32'h0, 4'b0000);
    send(0, 32'h600, 32'h0, 4'b0000);
    send(0, 32'h600, 32'h0, 4'b0000);
    respond(2'b01, 32'h77);
    ack = 0; valid = 1; write = 0; addr = 32'h700;
    #1;
    check("t6_pre_req", 32'(req), 32'd1);
    check("t6_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    valid = 0; rst_n = 0;
    #1;
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_req", 32'(req), 32'd0);
    idle(2);
    seen.delete();
    rst_n = 1; ack = 1; rsp_ready = 1;
    idle(1);
    send(0, 32'h604, 32'h0, 4'b0000);
    respond(2'b01, 32'h66);
    idle(3);
    check("t6_count", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) check("t6_data", 32'(seen[0]), 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
